// File: rtl/nn_pkg.sv
// Definitions shared by the pixel loader and the NeuralNetwork core.
// The frame geometry lives here so both blocks are always built from the same numbers.
package nn_pkg;

    localparam int NN_NUM_INPUTS      = 784;
    localparam int NN_PIX_WIDTH       = 8;
    localparam int NN_DATA_WIDTH      = 16;
    localparam int NN_DATA_FRAC_WIDTH = 8;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        FIRE = 2'd1,
        WAIT = 2'd2
    } ld_state_e;

    // Pixel to fixed point. The pixel fills the top of the fraction field,
    // or the result is exactly 1.0 / 0.0 when binarizing.
    function automatic logic [31:0] pix_to_fixed(
        input logic [31:0] pix,
        input int          pix_w,
        input int          frac_w,
        input bit          binarize,
        input logic [31:0] threshold
    );
        if (binarize) begin
            return (pix >= threshold) ? (32'd1 << frac_w) : 32'd0;
        end
        return pix << (frac_w - pix_w);
    endfunction

endpackage

// File: rtl/nn_pixel_convert.sv
// Combinational pixel -> fixed-point word, optional binarize against THRESHOLD.
// Latency 0 cycles; no flow control of its own.
module nn_pixel_convert
    import nn_pkg::*;
#(
    parameter int PIX_WIDTH       = NN_PIX_WIDTH,
    parameter int DATA_WIDTH      = NN_DATA_WIDTH,
    parameter int DATA_FRAC_WIDTH = NN_DATA_FRAC_WIDTH,
    parameter int BINARIZE        = 0,
    parameter int THRESHOLD       = 128
)(
    input  logic [PIX_WIDTH-1:0]  pix_dat,
    output logic [DATA_WIDTH-1:0] word_dat
);

    assign word_dat = DATA_WIDTH'(pix_to_fixed(32'(pix_dat), PIX_WIDTH, DATA_FRAC_WIDTH,
                                               BINARIZE != 0, 32'(THRESHOLD)));

endmodule

// File: rtl/nn_pixel_loader.sv
// Packs a serial pixel stream into one flat network input frame, then pulses nn_valid.
// nn_valid follows the last accept by 1 cycle; pix_ready stays low from FIRE until nn_out_valid.
module nn_pixel_loader
    import nn_pkg::*;
#(
    parameter int NUM_INPUTS      = NN_NUM_INPUTS,
    parameter int PIX_WIDTH       = NN_PIX_WIDTH,
    parameter int DATA_WIDTH      = NN_DATA_WIDTH,
    parameter int DATA_FRAC_WIDTH = NN_DATA_FRAC_WIDTH,
    parameter int BINARIZE        = 0,
    parameter int THRESHOLD       = 128
)(
    input  logic                             clk,
    input  logic                             reset,
    input  logic [PIX_WIDTH-1:0]             pix_data,
    input  logic                             pix_valid,
    input  logic                             pix_sof,
    output logic                             pix_ready,
    output logic [NUM_INPUTS*DATA_WIDTH-1:0] nn_in,
    output logic                             nn_valid,
    input  logic                             nn_out_valid,
    output logic                             busy,
    output logic                             sof_error,
    output logic [15:0]                      frame_count
);

    localparam int               IDX_W    = $clog2(NUM_INPUTS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_INPUTS - 1);

    ld_state_e                        state_q, state_d;
    logic [IDX_W-1:0]                 idx_q, idx_d, wr_idx;
    logic [NUM_INPUTS*DATA_WIDTH-1:0] nn_in_q, nn_in_d;
    logic                             sof_err_q, sof_err_d;
    logic [15:0]                      frame_count_q, frame_count_d;
    logic [DATA_WIDTH-1:0]            pix_word;
    logic                             accept;
    logic                             last_accept;

    nn_pixel_convert #(
        .PIX_WIDTH       (PIX_WIDTH),
        .DATA_WIDTH      (DATA_WIDTH),
        .DATA_FRAC_WIDTH (DATA_FRAC_WIDTH),
        .BINARIZE        (BINARIZE),
        .THRESHOLD       (THRESHOLD)
    ) u_convert (
        .pix_dat  (pix_data),
        .word_dat (pix_word)
    );

    assign accept      = pix_valid && pix_ready;
    // An SOF pixel restarts the frame, so it can never be the one that completes it.
    assign last_accept = accept && !pix_sof && (idx_q == LAST_IDX);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            LOAD:    if (last_accept) state_d = FIRE;
            FIRE:    state_d = nn_out_valid ? LOAD : WAIT;
            WAIT:    if (nn_out_valid) state_d = LOAD;
            default: state_d = LOAD;
        endcase
    end

    // Ready is gated by reset so the upstream sees no acceptance while held in reset.
    always_comb begin
        pix_ready = (state_q == LOAD) && reset;
        nn_valid  = (state_q == FIRE);
        busy      = (state_q != LOAD);
    end

    always_comb begin
        idx_d         = idx_q;
        nn_in_d       = nn_in_q;
        sof_err_d     = 1'b0;
        frame_count_d = frame_count_q;
        wr_idx        = pix_sof ? '0 : idx_q;
        if (accept) begin
            nn_in_d[wr_idx*DATA_WIDTH +: DATA_WIDTH] = pix_word;
            if (pix_sof) begin
                idx_d     = IDX_W'(1);
                sof_err_d = (idx_q != '0);
            end else if (idx_q == LAST_IDX) begin
                idx_d = '0;
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end
        if (state_q == FIRE) begin
            frame_count_d = frame_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx_q         <= '0;
            nn_in_q       <= '0;
            sof_err_q     <= 1'b0;
            frame_count_q <= '0;
        end else begin
            idx_q         <= idx_d;
            nn_in_q       <= nn_in_d;
            sof_err_q     <= sof_err_d;
            frame_count_q <= frame_count_d;
        end
    end

    assign nn_in       = nn_in_q;
    assign sof_error   = sof_err_q;
    assign frame_count = frame_count_q;

endmodule

// File: tb/tb_nn_pixel_loader.sv
// Bench for nn_pixel_loader: random pixel streams against a frame-level reference model.
module tb_nn_pixel_loader;

    localparam int N  = 784;
    localparam int DW = 16;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic [7:0]      pix_data = '0;
    logic            pix_valid = 1'b0;
    logic            pix_sof = 1'b0;
    logic            nn_out_valid = 1'b0;
    logic            pix_ready;
    logic [N*DW-1:0] nn_in;
    logic            nn_valid;
    logic            busy;
    logic            sof_error;
    logic [15:0]     frame_count;

    logic [7:0]      cv_pix = '0;
    logic [15:0]     cv_word;

    always #5 clk = ~clk;

    nn_pixel_loader dut (
        .clk          (clk),
        .reset        (reset),
        .pix_data     (pix_data),
        .pix_valid    (pix_valid),
        .pix_sof      (pix_sof),
        .pix_ready    (pix_ready),
        .nn_in        (nn_in),
        .nn_valid     (nn_valid),
        .nn_out_valid (nn_out_valid),
        .busy         (busy),
        .sof_error    (sof_error),
        .frame_count  (frame_count)
    );

    nn_pixel_convert #(.BINARIZE(1), .THRESHOLD(128)) u_bin (
        .pix_dat  (cv_pix),
        .word_dat (cv_word)
    );

    // Reference model: the image being assembled, the next slot to fill,
    // and where the frame is in its hand-off to the network.
    logic [15:0] img [N];
    int          fill;
    bit          m_load, m_fire, m_wait, m_sof_err;
    int          m_count;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          sof_seen = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int frame_diffs();
        int d = 0;
        for (int k = 0; k < N; k++) begin
            if (nn_in[k*DW +: DW] !== img[k]) d++;
        end
        return d;
    endfunction

    task automatic model_reset();
        fill = 0; m_load = 1; m_fire = 0; m_wait = 0; m_sof_err = 0; m_count = 0;
        for (int k = 0; k < N; k++) img[k] = '0;
    endtask

    // One clock: check what the last edge produced, then drive and predict the next edge.
    task automatic step(input bit v, input bit s, input logic [7:0] d, input bit ov);
        bit acc;
        int slot;
        @(negedge clk);
        check("pix_ready", pix_ready, m_load && reset);
        check("nn_valid", nn_valid, m_fire);
        check("busy", busy, m_fire || m_wait);
        check("sof_error", sof_error, m_sof_err);
        check("frame_count", frame_count, m_count[15:0]);
        if (m_fire || m_wait) check("frame_slots_diff", frame_diffs(), 0);
        if (sof_error === 1'b1) sof_seen++;
        pix_valid = v; pix_sof = s; pix_data = d; nn_out_valid = ov;
        if (reset) begin
            acc = v && m_load;
            m_sof_err = 0;
            if (m_fire) begin
                m_fire  = 0;
                m_count = (m_count + 1) % 65536;
                if (ov) m_load = 1; else m_wait = 1;
            end else if (m_wait) begin
                if (ov) begin m_wait = 0; m_load = 1; end
            end else if (acc) begin
                slot = s ? 0 : fill;
                img[slot] = {8'h00, d};
                if (s && fill != 0) m_sof_err = 1;
                fill = s ? 1 : fill + 1;
                if (fill == N) begin fill = 0; m_load = 0; m_fire = 1; end
            end
        end
    endtask

    task automatic send_pixels(input int n, input bit gaps, input bit ramp);
        int  got = 0;
        bit  was_load, v;
        logic [7:0] d;
        for (int t = 0; t < 20*n + 100 && got < n; t++) begin
            v = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            d = ramp ? 8'(got) : 8'($urandom);
            was_load = m_load;
            step(v, 1'b0, d, gaps ? ($urandom_range(0, 7) == 0) : 1'b0);
            if (v && was_load) got++;
        end
        check("pixels_sent", got, n);
    endtask

    initial begin
        model_reset();

        // Binarize option at the threshold boundary.
        cv_pix = 8'd127; #1 check("bin_127", cv_word, 16'h0000);
        cv_pix = 8'd128; #1 check("bin_128", cv_word, 16'h0100);
        cv_pix = 8'd0;   #1 check("bin_0",   cv_word, 16'h0000);
        cv_pix = 8'd255; #1 check("bin_255", cv_word, 16'h0100);

        // Held in reset with valid high: nothing may be accepted.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'h33, 1'b0);
        check("rst_nn_in_zero", |nn_in, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b0);
        reset = 1'b1;

        // Frame 1: ramp k mod 256, then 50 cycles of back-pressure while busy.
        send_pixels(N, 1'b0, 1'b1);
        for (int i = 0; i < 50; i++) step(1'b1, 1'b0, 8'hAA, 1'b0);
        check("f1_slot5", nn_in[5*DW +: DW], 16'h0005);
        check("f1_slot783", nn_in[783*DW +: DW], 16'h000F);
        check("f1_count", frame_count, 16'd1);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        step(1'b0, 1'b0, 8'h00, 1'b0);

        // Frame 2: SOF mid-frame restarts at slot 0 and flags an error once.
        sof_seen = 0;
        send_pixels(300, 1'b0, 1'b0);
        step(1'b1, 1'b1, 8'h11, 1'b0);
        send_pixels(N - 1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b0);
        check("f2_slot0", nn_in[0 +: DW], 16'h0011);
        check("f2_sof_pulses", sof_seen, 1);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        step(1'b0, 1'b0, 8'h00, 1'b0);

        // Asynchronous reset mid-frame discards the partial frame.
        send_pixels(400, 1'b0, 1'b0);
        #2 reset = 1'b0;
        #1;
        check("arst_pix_ready", pix_ready, 1'b0);
        check("arst_busy", busy, 1'b0);
        check("arst_nn_valid", nn_valid, 1'b0);
        check("arst_count", frame_count, 16'd0);
        check("arst_sof_error", sof_error, 1'b0);
        check("arst_nn_in_zero", |nn_in, 1'b0);
        model_reset();
        step(1'b0, 1'b0, 8'h00, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b0);
        reset = 1'b1;
        send_pixels(N - 1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b0);
        check("arst_no_early_fire", busy, 1'b0);
        send_pixels(1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        step(1'b0, 1'b0, 8'h00, 1'b0);
        check("arst_count_after", frame_count, 16'd1);

        // Random gaps, released in the FIRE cycle, two back-to-back frames.
        send_pixels(N, 1'b1, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        send_pixels(N, 1'b1, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        step(1'b0, 1'b0, 8'h00, 1'b0);
        check("rand_count", frame_count, 16'd3);
        check("rand_ready", pix_ready, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/nn_pixel_loader.md
Name: nn_pixel_loader

Overview:
- Upstream feeder for the NeuralNetwork core.
- Accepts a serial stream of 8-bit grayscale pixels over a valid/ready handshake and converts each pixel to Q8.8 fixed point.
- Packs one full frame (784 pixels) into the flat input vector, then issues a single-cycle valid pulse to the network.
- Holds the vector stable and back-pressures the stream until the network reports its output valid.

Parameters:
- NUM_INPUTS, 784, pixels per frame; must match the network's numInputs.
- PIX_WIDTH, 8, width of an incoming pixel.
- DATA_WIDTH, 16, width of one packed network input word.
- DATA_FRAC_WIDTH, 8, fractional bits of the packed word (Q8.8).
- BINARIZE, 0, when 1 each pixel maps to 1.0 or 0.0 via THRESHOLD.
- THRESHOLD, 128, binarization threshold; pixel >= THRESHOLD maps to 1.0.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- pix_data  in  PIX_WIDTH  incoming pixel value.
- pix_valid  in  1  pix_data is valid this cycle.
- pix_sof  in  1  start of frame; qualified by pix_valid.
- pix_ready  out  1  loader accepts a pixel this cycle.
- nn_in  out  NUM_INPUTS*DATA_WIDTH  packed frame; pixel k at [k*DATA_WIDTH +: DATA_WIDTH].
- nn_valid  out  1  one-cycle pulse: nn_in holds a complete frame.
- nn_out_valid  in  1  network result ready; releases the loader.
- busy  out  1  frame handed to the network, result not yet returned.
- sof_error  out  1  one-cycle pulse: pix_sof arrived mid-frame.
- frame_count  out  16  number of frames delivered; wraps at 65535 -> 0.

Behaviour:
- Reset values (reset low, asynchronous): state=LOAD, pixel index=0, nn_in=0, nn_valid=0, busy=0, sof_error=0, frame_count=0, pix_ready=0 while reset is low.
- A pixel is accepted when pix_valid && pix_ready at a rising clk edge.
- Conversion, BINARIZE=0: word = zero-extended pixel, left-aligned so that the fractional field holds the pixel. For the default widths this is {8'h00, pix}, so 255 maps to 0x00FF (about 0.996).
- Conversion, BINARIZE=1: word = 0x0100 if pix >= THRESHOLD, else 0x0000.
- State LOAD:
  - pix_ready=1.
  - Each accepted pixel is written to slot idx, then idx increments.
  - An accepted pixel with pix_sof=1 is written to slot 0 and idx becomes 1, regardless of the current idx.
  - If pix_sof=1 arrives while idx != 0, sof_error pulses for one cycle. Stale slots above 0 are not cleared; they are overwritten as the new frame fills.
  - Accepting the pixel at idx = NUM_INPUTS-1 moves the state to FIRE and resets idx to 0.
  - pix_sof is not required for the first frame after reset, since idx is already 0.
- State FIRE (one cycle):
  - nn_valid=1, pix_ready=0, busy=1, frame_count increments.
  - Next state is WAIT.
- State WAIT:
  - pix_ready=0, busy=1.
  - nn_in is held frozen.
  - On nn_out_valid=1 the state returns to LOAD and busy clears on the following cycle.
  - nn_out_valid arriving in the FIRE cycle is honoured: FIRE goes directly to LOAD.
- nn_out_valid is ignored in LOAD.
- Latency: the nn_valid pulse occurs in the cycle after the clock edge that accepts the last pixel.
- Throughput: one pixel per clock in LOAD.
- Reset asserted mid-frame or in WAIT returns the block to the reset state immediately; partial frames are discarded.
- nn_in is registered storage. A frame may overwrite it only in LOAD, and never while busy=1.

Decomposition:
- Shared package nn_pkg holds:
  - the state enum {LOAD, FIRE, WAIT};
  - NUM_INPUTS, DATA_WIDTH and DATA_FRAC_WIDTH defaults, shared with NeuralNetwork so the two blocks cannot disagree;
  - the pixel-to-Q8.8 conversion function.
- One natural sub-module, nn_pixel_convert: combinational PIX_WIDTH -> DATA_WIDTH conversion, including the binarize option, instantiated once.
- The FSM, index counter and packed register stay in the top-level loader.

Test Plan:
- Reset, then stream 784 pixels with pix=k mod 256 and pix_valid held high -> nn_valid pulses exactly once, one cycle after the last accept; nn_in slot 5 = 0x0005 and slot 783 = 0x000F; frame_count=1; pix_ready=0.
- While busy, drive pix_valid=1 with pix=0xAA for 50 cycles -> no pixel accepted and nn_in unchanged. Then pulse nn_out_valid -> busy=0 and pix_ready=1 on the next cycle.
- Send 300 pixels, then a pixel with pix_sof=1 and pix=0x11 -> sof_error pulses once; slot 0 = 0x0011; a further 783 pixels produce nn_valid.
- BINARIZE=1, THRESHOLD=128: pixels 127 and 128 -> words 0x0000 and 0x0100.
- Drop reset low after 400 pixels -> all outputs return to reset values asynchronously; after release, a full 784-pixel frame is needed before nn_valid.
- Drive random pix_valid gaps and return nn_out_valid in the FIRE cycle -> no pixel lost or duplicated; a second frame loads correctly; frame_count=2.
